// File: rtl/led_chain_scheduler.sv
// Frame controller for a WS2812-style LED chain: pixel buffer + pulse-width serialiser.
// Ports: i_clk, i_rst (async high), i_wr_en/i_wr_addr/i_wr_data host write port,
//   i_start frame request, o_busy, o_done pulse, o_serial chain data.
// Optional LED_AUTO_REFRESH_EN: frames repeat until i_stop; adds port i_stop.
module led_chain_scheduler #(
  parameter int NUM_LEDS     = 8,
  parameter int CLK_PER_BIT  = 125,
  parameter int T0H          = 40,
  parameter int T1H          = 80,
  parameter int LATCH_CYCLES = 5000,
  parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [23:0]   i_wr_data,
  input  logic          i_start,
`ifdef LED_AUTO_REFRESH_EN
  input  logic          i_stop,
`endif
  output logic          o_busy,
  output logic          o_done,
  output logic          o_serial
);

  localparam int CMAX = (LATCH_CYCLES > CLK_PER_BIT) ?
                        LATCH_CYCLES : CLK_PER_BIT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CPB_M1 = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] T0_M1  = CW'(T0H - 1);
  localparam logic [CW-1:0] T1_M1  = CW'(T1H - 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(LATCH_CYCLES - 1);
  localparam logic [AW-1:0] LAST   = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   NLEDS  = (AW + 1)'(NUM_LEDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HIGH, S_LOW, S_LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    bit_q, bit_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [23:0]   shift_q, shift_d;
  logic          serial_q, serial_d;
  logic [CW-1:0] th_m1;
  logic          lat_exit_idle;

  logic [23:0]   buf_q [NUM_LEDS];

  // Buffer is not reset; out-of-range addresses are dropped.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && ({1'b0, i_wr_addr} < NLEDS))
      buf_q[i_wr_addr] <= i_wr_data;
  end

`ifdef LED_AUTO_REFRESH_EN
  logic stop_q, stop_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stop_q <= 1'b0;
    else       stop_q <= stop_d;
  end

  always_comb begin
    stop_d = stop_q | i_stop;
    if (state_q == S_IDLE) stop_d = 1'b0;
  end

  assign lat_exit_idle = i_stop | stop_q;
`else
  assign lat_exit_idle = 1'b1;
`endif

  // Bit period uses one counter: high phase ends at th-1, low at CPB-1.
  assign th_m1 = shift_q[23] ? T1_M1 : T0_M1;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    shift_d = shift_q;
    o_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        pix_d = '0;
        if (i_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = buf_q[pix_q];
        bit_d   = '0;
        cyc_d   = '0;
        state_d = S_HIGH;
      end
      S_HIGH: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == th_m1) state_d = S_LOW;
      end
      S_LOW: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CPB_M1) begin
          cyc_d = '0;
          if (bit_q != 5'd23) begin
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[22:0], 1'b0};
            state_d = S_HIGH;
          end else if (pix_q != LAST) begin
            pix_d   = pix_q + 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == LAT_M1) begin
          o_done = 1'b1;
          cyc_d  = '0;
          pix_d  = '0;
          state_d = lat_exit_idle ? S_IDLE : S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered from the current state: one cycle behind, glitch-free.
  assign serial_d = (state_q == S_HIGH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      pix_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      pix_q    <= pix_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_serial = serial_q;

endmodule

// File: tb/tb_led_chain_scheduler.sv
// Bench for led_chain_scheduler: decodes the serial waveform into words
// and compares against a snapshot model of the pixel buffer.
`timescale 1ns/1ps
module tb_led_chain_scheduler;
  localparam int CPB = 10;
  localparam int LAT = 20;
  localparam int PIXLEN = 24 * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic stop = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic busy2, done2, ser2;
  logic busy3, done3, ser3;
  logic busy, done, ser;

  int n_chk = 0;
  int n_fail = 0;
  logic [23:0] mdl [2][3];

  assign busy = sel ? busy3 : busy2;
  assign done = sel ? done3 : done2;
  assign ser  = sel ? ser3  : ser2;

  always #5 clk = ~clk;

  led_chain_scheduler #(
    .NUM_LEDS(2), .CLK_PER_BIT(CPB), .T0H(3), .T1H(7), .LATCH_CYCLES(LAT)
  ) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_wr_en(wr_en & ~sel), .i_wr_addr(wr_addr[0:0]),
    .i_wr_data(wr_data), .i_start(start & ~sel),
`ifdef LED_AUTO_REFRESH_EN
    .i_stop(stop),
`endif
    .o_busy(busy2), .o_done(done2), .o_serial(ser2)
  );

  led_chain_scheduler #(
    .NUM_LEDS(3), .CLK_PER_BIT(CPB), .T0H(3), .T1H(7), .LATCH_CYCLES(LAT)
  ) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_wr_en(wr_en & sel), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start & sel),
`ifdef LED_AUTO_REFRESH_EN
    .i_stop(stop),
`endif
    .o_busy(busy3), .o_done(done3), .o_serial(ser3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (int'(a) < (sel ? 3 : 2)) mdl[sel][a] = d;
  endtask

  // Called right after a negedge. Kicks a frame, optionally writes
  // (wa,wd) in busy cycle wr_c and pokes i_start in cycles sa/sb/sc.
  task automatic run_frame(input int wr_c, input logic [1:0] wa,
                           input logic [23:0] wd,
                           input int sa, input int sb, input int sc);
    int npix, flen;
    int bn, hi, lo, dn, dat, fh, lat0, bad, pidx;
    bit seen;
    int highs[$];
    int lows[$];
    logic [23:0] exp_w, got_w;
    npix = sel ? 3 : 2;
    flen = npix * PIXLEN + LAT;
    bn = 0; hi = 0; lo = 0; dn = 0; dat = -1;
    fh = -1; lat0 = -1; bad = 0; seen = 1'b0;
    start = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (busy) begin
        if (!seen) lat0 = n;
        seen = 1'b1;
        if (ser) begin
          if (hi == 0 && fh >= 0) lows.push_back(lo);
          if (fh < 0) fh = bn;
          hi++;
          lo = 0;
        end else begin
          if (hi > 0) highs.push_back(hi);
          hi = 0;
          lo++;
        end
        if (done) begin dn++; dat = bn; end
        if (bn == wr_c) begin
          wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        end
        if (bn == sa || bn == sb || bn == sc) start = 1'b1;
        bn++;
      end else if (seen) begin
        break;
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
    check("start_latency", lat0, 0);
    check("busy_len", bn, flen);
    check("done_count", dn, 1);
    check("done_pos", dat, flen - 1);
    check("first_rise", fh, 2);
    check("bit_count", highs.size(), 24 * npix);
    if (highs.size() == 24 * npix && lows.size() == 24 * npix - 1) begin
      for (int i = 0; i < highs.size(); i++) begin
        if (highs[i] != 3 && highs[i] != 7) bad++;
        if (i < lows.size() &&
            highs[i] + lows[i] != CPB + ((i % 24) == 23 ? 1 : 0)) bad++;
      end
      check("pulse_shape", bad, 0);
      for (int p = 0; p < npix; p++) begin
        got_w = '0;
        for (int b = 0; b < 24; b++)
          got_w = {got_w[22:0], highs[p * 24 + b] == 7};
        exp_w = mdl[sel][p];
        if (wr_c >= 0 && wr_c < p * PIXLEN && int'(wa) == p) exp_w = wd;
        check($sformatf("pixel%0d", p), int'(got_w), int'(exp_w));
      end
    end
    if (wr_c >= 0 && int'(wa) < npix) mdl[sel][wa] = wd;
    @(negedge clk);
    check("idle_after", int'(busy), 0);
  endtask

  initial begin
`ifdef LED_AUTO_REFRESH_EN
    stop = 1'b1;
`endif
    #1;
    check("rst_busy2", int'(busy2), 0);
    check("rst_done2", int'(done2), 0);
    check("rst_ser2", int'(ser2), 0);
    check("rst_busy3", int'(busy3), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    sel = 1'b0;
    wr(2'd0, 24'hA50000);
    wr(2'd1, 24'h000001);
    run_frame(-1, 2'd0, 24'h0, -1, -1, -1);
    run_frame(-1, 2'd0, 24'h0, 100, 490, 501);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_ser", int'(ser2), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ser", int'(ser2), 0);
    check("async_rst_busy", int'(busy2), 0);
    check("async_rst_done", int'(done2), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stays_idle", int'(busy2), 0);
    run_frame(-1, 2'd0, 24'h0, -1, -1, -1);

    run_frame(50, 2'd1, 24'hFFFFFF, -1, -1, -1);
    run_frame(300, 2'd0, 24'h123456, -1, -1, -1);
    run_frame(-1, 2'd0, 24'h0, -1, -1, -1);
    for (int r = 0; r < 3; r++)
      run_frame(int'($urandom_range(0, 2 * PIXLEN + LAT - 1)),
                2'($urandom_range(0, 1)), 24'($urandom), -1, -1, -1);

    sel = 1'b1;
    @(negedge clk);
    wr(2'd0, 24'($urandom));
    wr(2'd1, 24'($urandom));
    wr(2'd2, 24'($urandom));
    wr(2'd3, 24'hDEADBE);
    run_frame(10, 2'd3, 24'h5A5A5A, -1, -1, -1);
    run_frame(-1, 2'd0, 24'h0, -1, -1, -1);
    sel = 1'b0;
    @(negedge clk);

`ifdef LED_AUTO_REFRESH_EN
    begin : auto_blk
      int prev, nd, blow, fell;
      prev = -1; nd = 0; blow = 0; fell = 0;
      stop = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 1600; n++) begin
        if (done2) begin
          if (prev >= 0) check("auto_period", n - prev, 2 * PIXLEN + LAT);
          prev = n;
          nd++;
        end
        if (!busy2) blow++;
        @(negedge clk);
      end
      check("auto_done_count", nd, 3);
      check("auto_busy_low", blow, 0);
      stop = 1'b1;
      for (int n = 0; n < 2 * PIXLEN + LAT + 5; n++) begin
        @(negedge clk);
        if (!busy2) begin fell = 1; break; end
      end
      check("auto_stop_idle", fell, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
